modinv_verify: RTL
==================

# modinv_verify

Checks a modular inverse by computing prod = (e · d) mod phi_n with bit-serial interleaved modular multiplication, and flags ok when prod == 1. It is the consumer of the private exponent d produced by the inverse unit. It sits between key generation and the key registers, so that a wrong d is never committed. Operation is one multiply iteration per cycle, MSB-first over d.

## Interface
- W, 32, operand width in bits
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-low
- in_valid  in  1  operand set offered
- in_ready  out  1  block idle and accepting operands
- e  in  W  public exponent
- d  in  W  candidate inverse; unsigned, already corrected into [0, phi_n)
- phi_n  in  W  modulus
- done  out  1  one-cycle pulse: result fields updated
- busy  out  1  high from acceptance until the done cycle, inclusive
- prod  out  W  (e·d) mod phi_n; 0 on error
- ok  out  1  prod == 1 and no error
- err  out  1  operands out of range

## Operation
- Handshake: operands are accepted on a rising edge where in_valid && in_ready. in_ready = (state == IDLE). While busy, in_valid is ignored and the inputs are not sampled.
- States:
  - IDLE → CHECK on acceptance; e, d and phi_n are latched.
  - CHECK → DONE with err=1 if phi_n < 2, e ≥ phi_n or d ≥ phi_n; otherwise → MUL with P=0 and bit index i=W-1.
  - MUL: each cycle, P ← 2P mod phi_n, then if d[i], P ← (P + e) mod phi_n; then i ← i-1. After i=0 is processed, → DONE.
  - DONE: done=1, prod=P, ok=(P==1), err latched; → IDLE.
- Arithmetic:
  - P < phi_n is invariant.
  - Intermediates are W+1 bits wide. Each reduction is a single conditional subtract of phi_n when the value is ≥ phi_n.
  - No multiplier or divider is used.
- Result fields prod, ok and err hold their values until the next done.
- Reset (reset_n low at a clock edge) takes effect from any state:
  - state=IDLE
  - P=0
  - prod=0, ok=0, err=0
  - done=0, busy=0
  - in_ready=1 from the following cycle
  - an aborted operation never produces done.

## Timing
- Acceptance edge = cycle k.
- CHECK occupies cycle k+1.
- MUL occupies cycles k+2 through k+W+1.
- done is high in cycle k+W+2 (latency W+2; 34 for W=32).
- Error path: done is high in cycle k+2.
- in_ready returns high in cycle k+W+3, so the next acceptance can happen at the end of that cycle. Back-to-back throughput is one result per W+3 cycles.
- busy is high for cycles k+1 through the done cycle.

## Configuration
- MODINV_VERIFY_SKIP_ZEROS_EN defined:
  - CHECK loads i with the index of the MSB of d. Leading zero iterations are skipped because they leave P=0.
  - MUL lasts max(1, bitlength(d)) cycles.
  - d=0 takes 1 MUL cycle and gives prod=0.
  - Latency = 2 + max(1, bitlength(d)).
- Not defined: MUL always takes W cycles, giving fixed latency.
- Results are identical in both builds.

## Structure
- Package modinv_pkg:
  - state enum: IDLE, CHECK, MUL, DONE
  - default width constant MODINV_W = 32
  - shared with the inverse unit.
- Sub-module modmul_step is combinational. It takes (P, e, phi_n, bit) and returns the next P, doing the double, conditional subtract, conditional add and conditional subtract. It is instantiated once, and the bench uses it for unit checks.
- Leading-one detector: inline, present only under the macro.

## Test plan
- e=17, phi_n=3120, d=2753 → prod=1, ok=1, err=0. done at k+34 (k+14 with SKIP_ZEROS).
- e=17, phi_n=3120, d=2752 → prod=3104, ok=0, err=0.
- phi_n=1, or d=3120 with phi_n=3120 → done at k+2, err=1, ok=0, prod=0.
- Carry edge: phi_n=0xFFFFFFFB, e=2, d=0x7FFFFFFE → prod=1, ok=1. This exercises the W+1-bit intermediate.
- Reset mid-operation: reset_n low during the 10th MUL cycle → next cycle busy=0, in_ready=1, prod/ok/err=0, no done. A new operation then completes normally.
- Back-to-back: in_valid held high with two operand sets → second acceptance on the in_ready cycle after the first done. While busy, input changes have no effect on the first result.

Source files
------------

// File: rtl/modinv_pkg.sv
// Shared types and constants for the modular-inverse unit and its verifier.
package modinv_pkg;

  localparam int unsigned MODINV_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    MUL,
    DONE
  } modinv_state_e;

endpackage

// File: rtl/modmul_step.sv
// One MSB-first interleaved modular multiply step: p_o = (2*p_i + (bit_i ? e_i : 0)) mod phi_n_i.
// Requires p_i < phi_n_i and e_i < phi_n_i; every intermediate fits in W+1 bits.
module modmul_step
  import modinv_pkg::*;
#(
  parameter int unsigned W = MODINV_W
) (
  input  logic [W-1:0] p_i,
  input  logic [W-1:0] e_i,
  input  logic [W-1:0] phi_n_i,
  input  logic         bit_i,
  output logic [W-1:0] p_o
);

  logic [W:0]   dbl;
  logic [W-1:0] dbl_red;
  logic [W:0]   sum;

  always_comb begin
    dbl     = {p_i, 1'b0};
    // Difference is below phi_n, so the low W bits are the exact result.
    dbl_red = (dbl >= {1'b0, phi_n_i}) ? (dbl[W-1:0] - phi_n_i) : dbl[W-1:0];
    sum     = {1'b0, dbl_red} + {1'b0, (bit_i ? e_i : {W{1'b0}})};
    p_o     = (sum >= {1'b0, phi_n_i}) ? (sum[W-1:0] - phi_n_i) : sum[W-1:0];
  end

endmodule

// File: rtl/modinv_verify.sv
// Verifies a modular inverse: prod = (e*d) mod phi_n, ok when prod == 1.
// Define MODINV_VERIFY_SKIP_ZEROS_EN to skip the leading-zero iterations of d.
module modinv_verify
  import modinv_pkg::*;
#(
  parameter int unsigned W = MODINV_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] e,
  input  logic [W-1:0] d,
  input  logic [W-1:0] phi_n,
  output logic         done,
  output logic         busy,
  output logic [W-1:0] prod,
  output logic         ok,
  output logic         err
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  modinv_state_e state_q, state_d;
  logic [W-1:0]  e_q, e_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  phi_q, phi_d;
  logic [W-1:0]  p_q, p_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  prod_q, prod_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [W-1:0]  p_next;
  logic [IW-1:0] start_idx;
  logic          bad_ops;

  modmul_step #(
    .W(W)
  ) u_step (
    .p_i    (p_q),
    .e_i    (e_q),
    .phi_n_i(phi_q),
    .bit_i  (d_q[idx_q]),
    .p_o    (p_next)
  );

`ifdef MODINV_VERIFY_SKIP_ZEROS_EN
  // Leading-one detector; d == 0 maps to index 0 so one MUL cycle still runs.
  always_comb begin
    start_idx = '0;
    for (int unsigned b = 0; b < W; b++) begin
      if (d_q[b]) start_idx = IW'(b);
    end
  end
`else
  assign start_idx = IW'(W - 1);
`endif

  assign bad_ops = (phi_q < W'(2)) || (e_q >= phi_q) || (d_q >= phi_q);

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    d_d     = d_q;
    phi_d   = phi_q;
    p_d     = p_q;
    idx_d   = idx_q;
    prod_d  = prod_q;
    ok_d    = ok_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          e_d     = e;
          d_d     = d;
          phi_d   = phi_n;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bad_ops) begin
          prod_d  = '0;
          ok_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          p_d     = '0;
          idx_d   = start_idx;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d = p_next;
        if (idx_q == '0) begin
          prod_d  = p_next;
          ok_d    = (p_next == W'(1));
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      e_q     <= '0;
      d_q     <= '0;
      phi_q   <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      prod_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      d_q     <= d_d;
      phi_q   <= phi_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      prod_q  <= prod_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign prod     = prod_q;
  assign ok       = ok_q;
  assign err      = err_q;

endmodule
